// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge.
//   - apb_mst_state_e : bridge FSM state
//   - TimeoutCyclesDefault : default wait-state abort limit
//   - cnt_width() : width of the wait-state counter for a given limit
package apb_master_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } apb_mst_state_e;

  localparam int unsigned TimeoutCyclesDefault = 256;

  // Counter must hold values up to TIMEOUT_CYCLES; always at least 1 bit wide.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB master bridge.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   clear_i   : restart counting from zero
//   en_i      : count one wait cycle
//   expired_o : counter has reached TIMEOUT_CYCLES-1 (never asserts when TIMEOUT_CYCLES=0)
module apb_timeout_cnt
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_o = (cnt_q == LastCnt);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Request/grant command interface to APB3 master, one transfer outstanding.
//   HCLK, HRESET          : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i, gnt_o : command side (fields sampled on gnt_o)
//   rvalid_o/rdata_o/err_o : one-cycle response; rdata_o/err_o hold between responses
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY/PSLVERR : APB3 master port
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam logic [APB_ADDR_WIDTH-1:0] WordMask = {{(APB_ADDR_WIDTH-2){1'b1}}, 2'b00};

  apb_mst_state_e            state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      cnt_clr, cnt_en, cnt_expired;

  // HRESET gating keeps gnt_o low for the whole reset, not just after the state settles.
  assign gnt_o = req_i && (state_q == StIdle) && !HRESET;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .clear_i  (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(cnt_expired)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_o) begin
          state_d  = StSetup;
          paddr_d  = addr_i & WordMask;
          pwrite_d = we_i;
          pwdata_d = we_i ? wdata_i : 32'h0;
          cnt_clr  = 1'b1;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        // PREADY wins over a timeout landing in the same cycle.
        if (PREADY) begin
          state_d  = StIdle;
          rvalid_d = 1'b1;
          err_d    = PSLVERR;
          rdata_d  = (!pwrite_q && !PSLVERR) ? PRDATA : 32'h0;
        end else begin
          cnt_en = 1'b1;
          if (cnt_expired) begin
            state_d  = StIdle;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = 32'h0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Decoded straight from the state register so they drop with HRESET asynchronously.
  assign PSEL     = (state_q != StIdle);
  assign PENABLE  = (state_q == StAccess);
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_i, we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;
  logic [11:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to a sampling window well after the active edge.
  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  // One transfer from grant to response. waits = ACCESS cycles with PREADY low
  // before PREADY rises (large value = hung slave); exp_acc = expected PENABLE cycles.
  task automatic run_xfer(input string name, input logic we, input logic [11:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic [31:0] prdata, input logic slverr,
                          input logic [11:0] exp_paddr, input logic [31:0] exp_pwdata,
                          input int exp_acc, input logic [31:0] exp_rdata,
                          input logic exp_err);
    int n;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    #1;
    check({name, ".gnt"}, 32'(gnt_o), 32'd1);
    step();
    req_i = 1'b0;
    check({name, ".setup_psel"}, 32'(PSEL), 32'd1);
    check({name, ".setup_penable"}, 32'(PENABLE), 32'd0);
    check({name, ".paddr"}, 32'(PADDR), 32'(exp_paddr));
    check({name, ".pwdata"}, PWDATA, exp_pwdata);
    check({name, ".pwrite"}, 32'(PWRITE), 32'(we));
    step();
    n = 0;
    while (PENABLE && n < 20) begin
      PREADY  = (n == waits);
      PSLVERR = slverr;
      PRDATA  = prdata;
      n++;
      step();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    check({name, ".access_cycles"}, 32'(n), 32'(exp_acc));
    check({name, ".rvalid"}, 32'(rvalid_o), 32'd1);
    check({name, ".err"}, 32'(err_o), 32'(exp_err));
    check({name, ".rdata"}, rdata_o, exp_rdata);
    check({name, ".idle_psel"}, 32'(PSEL), 32'd0);
    check({name, ".paddr_hold"}, 32'(PADDR), 32'(exp_paddr));
    step();
    check({name, ".rvalid_drop"}, 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    HRESET = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 12'hFFF; wdata_i = 32'hFFFF_FFFF;
    PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    #12;
    check("rst.gnt", 32'(gnt_o), 32'd0);
    check("rst.psel", 32'(PSEL), 32'd0);
    check("rst.penable", 32'(PENABLE), 32'd0);
    check("rst.pwrite", 32'(PWRITE), 32'd0);
    check("rst.paddr", 32'(PADDR), 32'd0);
    check("rst.pwdata", PWDATA, 32'd0);
    check("rst.rvalid", 32'(rvalid_o), 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    step();
    HRESET = 1'b0;
    step();

    // Zero-wait write: wdata in PWDATA, response data forced to 0.
    run_xfer("wr0", 1'b1, 12'h00C, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b0,
             12'h00C, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    // Read, 3 wait states; PREADY arrives in the 4th ACCESS cycle (timeout boundary).
    run_xfer("rd3", 1'b0, 12'h007, 32'hAAAA_AAAA, 3, 32'h0000_0055, 1'b0,
             12'h004, 32'h0, 4, 32'h0000_0055, 1'b0);
    // Slave error on read.
    run_xfer("slverr", 1'b0, 12'h010, 32'h0, 0, 32'hFFFF_FFFF, 1'b1,
             12'h010, 32'h0, 1, 32'h0, 1'b1);
    // Hung slave: aborted after 4 ACCESS cycles.
    run_xfer("tmo", 1'b0, 12'h022, 32'h0, 100, 32'h0000_0099, 1'b0,
             12'h020, 32'h0, 4, 32'h0, 1'b1);
    // Write completing in the 4th ACCESS cycle beats the timeout.
    run_xfer("tmo_edge", 1'b1, 12'h030, 32'h0BAD_F00D, 3, 32'h0, 1'b0,
             12'h030, 32'h0BAD_F00D, 4, 32'h0, 1'b0);

    // Back-to-back writes with req_i held: grants at 0,3,6; responses at 3,6,9.
    PREADY = 1'b1; we_i = 1'b1; req_i = 1'b1;
    for (int w = 0; w < 10; w++) begin
      if (w == 7) req_i = 1'b0;
      addr_i  = 12'(16 * w);
      wdata_i = 32'h100 + 32'(w);
      #1;
      check($sformatf("b2b.gnt%0d", w), 32'(gnt_o), 32'((w % 3 == 0) && (w <= 6)));
      check($sformatf("b2b.rvalid%0d", w), 32'(rvalid_o), 32'((w % 3 == 0) && (w >= 3)));
      if (w % 3 == 1 && w <= 7)
        check($sformatf("b2b.pwdata%0d", w), PWDATA, 32'h100 + 32'(w - 1));
      step();
    end
    PREADY = 1'b0;

    // Reset while the slave is stalling in ACCESS.
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h040;
    step();
    req_i = 1'b0;
    step();
    check("rstacc.penable_before", 32'(PENABLE), 32'd1);
    step();
    HRESET = 1'b1;
    #1;
    check("rstacc.psel", 32'(PSEL), 32'd0);
    check("rstacc.penable", 32'(PENABLE), 32'd0);
    step();
    check("rstacc.rvalid", 32'(rvalid_o), 32'd0);
    HRESET = 1'b0;
    step();
    check("rstacc.rvalid_after", 32'(rvalid_o), 32'd0);
    // Fresh read at the timeout boundary also proves the counter was cleared.
    run_xfer("post_rst", 1'b0, 12'h05C, 32'h0, 3, 32'hCAFE_0001, 1'b0,
             12'h05C, 32'h0, 4, 32'hCAFE_0001, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple core-side request/grant command interface into APB3 master transfers, one outstanding transfer at a time.
- Lets cores and DMA-like agents reach the team's APB peripherals: event/interrupt units, timers, and similar slaves.
- Completes wait-state transfers via PREADY and returns PRDATA and PSLVERR as a one-cycle response.
- A timeout aborts transfers to hung slaves.

Parameters:
- APB_ADDR_WIDTH, 12, width of addr_i and PADDR (4KB slave window).
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous reset, active-high.
- req_i  in  1  command request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  APB_ADDR_WIDTH  byte address; bits [1:0] are ignored.
- wdata_i  in  32  write data.
- gnt_o  out  1  command accepted this cycle.
- rvalid_o  out  1  one-cycle response strobe.
- rdata_o  out  32  read data; 0 for writes, errors and timeouts.
- err_o  out  1  response error (PSLVERR or timeout); valid with rvalid_o.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset: state IDLE. All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rvalid_o, rdata_o, err_o. gnt_o is 0 while HRESET is high.
- FSM states: IDLE, SETUP, ACCESS.
- gnt_o = req_i && state==IDLE (combinational). Command fields are sampled only when gnt_o=1.
- IDLE -> SETUP on grant. Latch PADDR = {addr_i[APB_ADDR_WIDTH-1:2], 2'b00} and PWRITE = we_i. PWDATA = wdata_i for writes, 0 for reads.
- SETUP: PSEL=1, PENABLE=0. Always -> ACCESS after one cycle.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA are held stable.
- ACCESS with PREADY=1: -> IDLE. Next cycle rvalid_o=1 for exactly one cycle, err_o=PSLVERR. rdata_o = PRDATA on a read without error, else 0.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter. The counter clears on entry to SETUP.
- Timeout: TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with PREADY still 0 -> -> IDLE, drop PSEL/PENABLE. Next cycle rvalid_o=1, err_o=1, rdata_o=0. A PREADY=1 arriving in that final cycle takes priority over the timeout.
- Latency, zero-wait slave: grant at T, SETUP T+1, ACCESS T+2, rvalid_o T+3.
- Throughput: a new grant is possible at T+3, the same cycle as rvalid_o, giving back-to-back transfers every 3 cycles.
- PSEL and PENABLE are both 0 in IDLE. PADDR, PWRITE and PWDATA keep their last values in IDLE to limit toggling.
- rdata_o and err_o hold their value until the next response. Consumers use them only when rvalid_o=1.
- req_i changes while not granted are ignored; no stored state is affected.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously. No rvalid_o is generated. The counter clears.

Decomposition:
- Package apb_master_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS};
  - default TIMEOUT_CYCLES constant;
  - function deriving the counter width as $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Sub-module apb_timeout_cnt:
  - inputs: clear, count-enable;
  - output: expired;
  - tied off (never expires) when TIMEOUT_CYCLES=0.
- The FSM, address/data latches and response register stay in apb_master_bridge.

Test Plan:
- Zero-wait write: req_i=1, we_i=1, addr_i=0x00C, wdata_i=0xDEADBEEF -> gnt_o at T; PSEL T+1 and T+2; PENABLE T+2; PADDR=0x00C, PWDATA=0xDEADBEEF; rvalid_o T+3, err_o=0, rdata_o=0.
- Read with 3 wait states: addr_i=0x007, slave PREADY low for 3 ACCESS cycles, PRDATA=0x0000_0055 -> PADDR=0x004; PENABLE high 4 cycles; rvalid_o once; rdata_o=0x55.
- Slave error: read with PSLVERR=1, PRDATA=0xFFFFFFFF -> err_o=1, rdata_o=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> PENABLE high exactly 4 cycles, then PSEL=0; rvalid_o with err_o=1. PREADY=1 in the 4th ACCESS cycle instead -> normal completion, err_o=0.
- Back-to-back: req_i held high for 3 writes -> grants at T, T+3, T+6; rvalid_o at T+3, T+6, T+9; gnt_o and rvalid_o coincide at T+3.
- Reset in ACCESS: HRESET asserted mid-wait -> PSEL=PENABLE=0 the same cycle, no rvalid_o. After release, a fresh read completes normally.
